and_self: RTL and testbench

- Parameterised reduction-AND monitor on an N-bit input word.
- Primary output y is the combinational AND of all input bits.
- Registered companions: a delayed copy of y, edge pulses, a saturating count of consecutive all-ones cycles, and the index of the lowest zero bit.
- Used as a small status and diagnostic leaf under a single clock domain.

---
 rtl/and_self_if.sv | 36 +++
 rtl/and_self.sv | 82 ++++++++
 tb/tb_and_self.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/and_self_if.sv
// Bus bundle for the and_self reduction-AND monitor: data word and clear in, status out.
// The sticky flag exists only when ANDSELF_STICKY_EN is defined.
interface and_self_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
);
  logic [WIDTH-1:0] a;
  logic             clr;
  logic             y;
  logic             y_q;
  logic             y_rise;
  logic             y_fall;
  logic [CNT_W-1:0] ones_cnt;
  logic             zero_valid;
  logic [IDX_W-1:0] zero_idx;
`ifdef ANDSELF_STICKY_EN
  logic             sticky;
`endif

  modport master (
    output a, clr,
    input  y, y_q, y_rise, y_fall, ones_cnt, zero_valid, zero_idx
`ifdef ANDSELF_STICKY_EN
    , input sticky
`endif
  );

  modport slave (
    input  a, clr,
    output y, y_q, y_rise, y_fall, ones_cnt, zero_valid, zero_idx
`ifdef ANDSELF_STICKY_EN
    , output sticky
`endif
  );
endinterface

// File: rtl/and_self.sv
// Reduction-AND monitor: combinational y plus registered delay, edge pulses, saturating
// all-ones run counter and lowest-zero index. Optional sticky flag under ANDSELF_STICKY_EN.
module and_self #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  and_self_if.slave bus
);
  logic             y;
  logic             yq_q;
  logic             rise_q;
  logic             fall_q;
  logic             zv_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign y = &bus.a;

  // Scan from the top so the lowest-numbered zero bit wins.
  always_comb begin
    idx_d = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!bus.a[i]) idx_d = IDX_W'(i);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr || !y) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yq_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      zv_q   <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      yq_q   <= y;
      rise_q <= y & ~yq_q;
      fall_q <= ~y & yq_q;
      zv_q   <= ~y;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
    end
  end

  assign bus.y          = y;
  assign bus.y_q        = yq_q;
  assign bus.y_rise     = rise_q;
  assign bus.y_fall     = fall_q;
  assign bus.ones_cnt   = cnt_q;
  assign bus.zero_valid = zv_q;
  assign bus.zero_idx   = idx_q;

`ifdef ANDSELF_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (bus.clr) begin
      sticky_q <= 1'b0;
    end else if (y) begin
      sticky_q <= 1'b1;
    end
  end

  assign bus.sticky = sticky_q;
`endif
endmodule

// File: tb/tb_and_self.sv
// Self-checking bench for and_self: vector table with scoreboard queue, plus reset,
// saturation (CNT_W=4) and WIDTH=1 sequences.
module tb_and_self;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  and_self_if #(.WIDTH(8), .CNT_W(8), .IDX_W(3)) bus1 ();
  and_self_if #(.WIDTH(8), .CNT_W(4), .IDX_W(3)) bus2 ();
  and_self_if #(.WIDTH(1), .CNT_W(8), .IDX_W(1)) bus3 ();

  and_self #(.WIDTH(8), .CNT_W(8), .IDX_W(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  and_self #(.WIDTH(8), .CNT_W(4), .IDX_W(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  and_self #(.WIDTH(1), .CNT_W(8), .IDX_W(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  typedef struct {
    logic [7:0] a;
    logic       clr;
    logic       yq;
    logic       rise;
    logic       fall;
    logic [7:0] cnt;
    logic       zv;
    logic [2:0] idx;
    logic       stk;
  } vec_t;

  vec_t tbl[20];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, queue the expectation, compare after the edge, return at negedge.
  task automatic step(input vec_t v);
    vec_t e;
    bus1.a   = v.a;
    bus1.clr = v.clr;
    sb_q.push_back(v);
    #1;
    chk("y_comb", {31'd0, bus1.y}, {31'd0, (v.a == 8'hFF)});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("y_q", {31'd0, bus1.y_q}, {31'd0, e.yq});
    chk("y_rise", {31'd0, bus1.y_rise}, {31'd0, e.rise});
    chk("y_fall", {31'd0, bus1.y_fall}, {31'd0, e.fall});
    chk("ones_cnt", {24'd0, bus1.ones_cnt}, {24'd0, e.cnt});
    chk("zero_valid", {31'd0, bus1.zero_valid}, {31'd0, e.zv});
    chk("zero_idx", {29'd0, bus1.zero_idx}, {29'd0, e.idx});
`ifdef ANDSELF_STICKY_EN
    chk("sticky", {31'd0, bus1.sticky}, {31'd0, e.stk});
`endif
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic [7:0] ra;
    logic a1;
    logic [7:0] exp_cnt;

    //        a      clr  yq   rise fall cnt   zv   idx   stk
    tbl[0]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 3'd0, 1'b1};
    tbl[1]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 3'd0, 1'b1};
    tbl[2]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 1'b1};
    tbl[3]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 3'd0, 1'b1};
    tbl[4]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 3'd0, 1'b1};
    tbl[5]  = '{8'hFB, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 3'd2, 1'b1};
    tbl[6]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 3'd0, 1'b1};
    tbl[7]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 3'd0, 1'b1};
    tbl[8]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b0};
    tbl[9]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 3'd0, 1'b1};
    tbl[10] = '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 3'd7, 1'b1};
    tbl[11] = '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd7, 1'b1};
    tbl[12] = '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd7, 1'b0};
    tbl[13] = '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd7, 1'b0};
    tbl[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0, 1'b0};
    tbl[15] = '{8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0, 1'b0};
    tbl[16] = '{8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd4, 1'b0};
    tbl[17] = '{8'hBF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd6, 1'b0};
    tbl[18] = '{8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0, 1'b0};
    tbl[19] = '{8'hF7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd3, 1'b0};

    bus1.a = 8'hFF; bus1.clr = 1'b0;
    bus2.a = 8'hFF; bus2.clr = 1'b0;
    bus3.a = 1'b0;  bus3.clr = 1'b0;

    // Reset with all-ones input: y high, registers held low across an edge.
    @(posedge clk);
    #2;
    chk("rst_y", {31'd0, bus1.y}, 32'd1);
    chk("rst_y_q", {31'd0, bus1.y_q}, 32'd0);
    chk("rst_rise", {31'd0, bus1.y_rise}, 32'd0);
    chk("rst_cnt", {24'd0, bus1.ones_cnt}, 32'd0);
    chk("rst_zv", {31'd0, bus1.zero_valid}, 32'd0);
    chk("rst_idx", {29'd0, bus1.zero_idx}, 32'd0);
`ifdef ANDSELF_STICKY_EN
    chk("rst_sticky", {31'd0, bus1.sticky}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) step(tbl[i]);

    // Only 00/01 on the word: never all ones.
    for (int i = 0; i < 12; i++) begin
      ra = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h00;
      v = '{ra, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, (ra == 8'h01) ? 3'd1 : 3'd0, 1'b0};
      step(v);
    end

    // Build a run, then reset asynchronously mid-cycle.
    step('{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 3'd0, 1'b1});
    step('{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 3'd0, 1'b1});
    step('{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 3'd0, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y_q", {31'd0, bus1.y_q}, 32'd0);
    chk("arst_cnt", {24'd0, bus1.ones_cnt}, 32'd0);
    chk("arst_y", {31'd0, bus1.y}, 32'd1);
    chk("arst_cnt4", {28'd0, bus2.ones_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 20 all-ones edges: 8-bit counter counts, 4-bit counter pins at 15.
    for (int k = 1; k <= 20; k++) begin
      v = '{8'hFF, 1'b0, 1'b1, (k == 1), 1'b0, 8'(k), 1'b0, 3'd0, 1'b1};
      step(v);
      exp_cnt = (k > 15) ? 8'd15 : 8'(k);
      chk("sat_cnt4", {28'd0, bus2.ones_cnt}, {24'd0, exp_cnt});
    end

    // WIDTH = 1 leaf: y follows a[0], zero_idx stays 0.
    for (int i = 0; i < 6; i++) begin
      a1 = (i % 3) != 0;
      bus3.a = a1;
      #1;
      chk("w1_y", {31'd0, bus3.y}, {31'd0, a1});
      @(posedge clk);
      #1;
      chk("w1_zv", {31'd0, bus3.zero_valid}, {31'd0, ~a1});
      chk("w1_idx", {31'd0, bus3.zero_idx}, 32'd0);
      @(negedge clk);
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
